u_rf_wb_arb: RTL and testbench
==============================

U_RF_WB_ARB -- requirements
Module: u_rf_wb_arb

Interface
REQ-001 SHALL have ports, clock and reset first (name direction width meaning):
- clk in 1: sole clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- dec_v in 1: decode slot holds an instruction.
- dec_rs1_a in 5: decode source 1 address.
- dec_rs2_a in 5: decode source 2 address.
- dec_rd_a in 5: decode destination address.
- stall_o out 1: hazard; decode must hold.
- alu_v, lsu_v, mdu_v in 1 each: writeback request valid.
- alu_rd, lsu_rd, mdu_rd in 5 each: writeback destination.
- alu_d, lsu_d, mdu_d in 32 each: writeback data.
- alu_rdy, lsu_rdy, mdu_rdy out 1 each: writeback accepted this cycle.
- rd_e out 1: regfile write enable.
- rd_a out 5: regfile write address.
- rd_i out 32: regfile write data.
REQ-002 SHALL use parameter NREQ, default 3, meaning the number of writeback requesters; ALU=0, LSU=1, MDU=2.

Function
REQ-003 SHALL grant at most one requester per cycle; a transfer occurs when v and rdy are both high.
REQ-004 SHALL drive rdy combinationally from the current v inputs and the arbitration pointer.
REQ-005 SHALL arbitrate round-robin: search starts at the index after the last granted requester and wraps 2->0; after reset the search starts at ALU.
REQ-006 SHALL update the pointer only on a transfer; a requester with v high and rdy low SHALL hold rd and d stable until granted.
REQ-007 SHALL register the granted request, so rd_e/rd_a/rd_i are asserted exactly one cycle after the transfer cycle, for one cycle.
REQ-008 SHALL accept a request with rd==0 (rdy high per arbitration), leave rd_e low in the following cycle, and still advance the pointer.
REQ-009 SHALL keep a 32-bit scoreboard pend[31:0]; pend[0] is constantly 0.
REQ-010 SHALL set pend[dec_rd_a] on issue (dec_v & ~stall_o & dec_rd_a!=0).
REQ-011 SHALL clear pend[rd_a] in the cycle rd_e is high.
REQ-012 SHALL give set priority when a set and a clear hit the same index in the same cycle; the bit stays 1.
REQ-013 SHALL compute per source s in {rs1, rs2}: hz_s = pend[s] & ~(rd_e & rd_a==s); the regfile forwards rd_i, so a register being written this cycle is not a hazard.
REQ-014 SHALL compute stall_o = dec_v & (hz_rs1 | hz_rs2 | (pend[dec_rd_a] & ~(rd_e & rd_a==dec_rd_a))); this covers RAW and WAW, and address 0 never stalls.
REQ-015 SHALL drive stall_o combinationally with zero-cycle latency.
REQ-016 SHALL, when all v inputs are low, assert no rdy and drive rd_e low next cycle; rd_a/rd_i hold their last values.

Reset
REQ-017 SHALL, while rst_n is low (asynchronous assertion), force: pend=0, pointer=ALU, rd_e=0, rd_a=0, rd_i=0.
REQ-018 SHALL make stall_o=0 and all rdy=0 follow combinationally from the reset state and inputs.
REQ-019 SHALL, on reset mid-operation, discard any registered write (no rd_e pulse after release) and drop all pending bits; re-issue is the pipeline's responsibility.
REQ-020 SHALL release reset synchronously with respect to clk; synchronisation of rst_n is external.

Structure
REQ-021 SHALL place in shared package rv_pkg: requester index enum (REQ_ALU, REQ_LSU, REQ_MDU), NREQ, a wb_req_t struct {v, rd[4:0], d[31:0]}, and REG_AW=5.
REQ-022 SHALL implement the arbiter as sub-module u_rr_arb (NREQ-wide req in, one-hot gnt out, pointer internal); the scoreboard and write register stay in u_rf_wb_arb.
REQ-023 SHALL connect rd_e/rd_a/rd_i directly to u_rf with no intervening logic.

Verification
REQ-024 Bench SHALL cover: alu_v, lsu_v, mdu_v high continuously from reset -> grants ALU, LSU, MDU, ALU...; rd_e high every cycle one cycle after each grant.
REQ-025 Bench SHALL cover: issue rd=5, then next cycle dec_rs1_a=5 -> stall_o=1 until the cycle lsu writes x5 (rd_e=1, rd_a=5), in which cycle stall_o=0 and pend[5] clears after the edge.
REQ-026 Bench SHALL cover: issue dec_rd_a=7 in the same cycle rd_e=1, rd_a=7 -> pend[7]=1 afterwards (set wins); a later dec_rs2_a=7 stalls.
REQ-027 Bench SHALL cover: mdu_v with mdu_rd=0, mdu_d=0xDEADBEEF -> mdu_rdy=1, rd_e=0 next cycle; dec_rs1_a=0 never stalls.
REQ-028 Bench SHALL cover: rst_n pulsed low for 1 ns mid-cycle with pend=0x0000_0F00 and a write registered -> immediate pend=0, rd_e=0, and no write after release.
REQ-029 Bench SHALL cover: lsu_v held high while alu_v and mdu_v are both high -> lsu_rd/lsu_d stay stable and LSU is granted within 2 cycles.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the register-file writeback path
//
// Purpose: requester indices, request struct, register address width and the
// per-source hazard helper used by the writeback arbiter / scoreboard.

package rv_pkg;

  localparam int NREQ   = 3;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_MDU = 2'd2
  } req_idx_e;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic [31:0]       d;
  } wb_req_t;

  // A pending register is not a hazard in the cycle it is being written,
  // because the regfile forwards the write data to the read ports.
  function automatic logic src_hazard(input logic [NREGS-1:0]  pend,
                                      input logic              we,
                                      input logic [REG_AW-1:0] wa,
                                      input logic [REG_AW-1:0] a);
    return pend[a] & ~(we & (wa == a));
  endfunction

endpackage

// File: rtl/u_rr_arb.sv
// rtl/u_rr_arb.sv - round-robin arbiter with one-hot grant
//
// Purpose: grant at most one of N requesters per cycle, searching from the
// index after the last grant. Every grant is a transfer, so the pointer moves
// whenever any request is granted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req [N]    : request vector
//   gnt [N]    : one-hot grant, combinational from req and pointer

module u_rr_arb #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/u_rf_wb_arb.sv
// rtl/u_rf_wb_arb.sv - writeback arbiter, register write stage and hazard scoreboard
//
// Purpose: arbitrate ALU/LSU/MDU writebacks round-robin into one registered
// regfile write port, and track in-flight destinations to stall decode on
// RAW/WAW hazards.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   dec_v, dec_rs1_a/rs2_a/rd_a    : decode slot and its register addresses
//   stall_o                        : decode must hold (combinational)
//   {alu,lsu,mdu}_v/_rd/_d         : writeback requests
//   {alu,lsu,mdu}_rdy              : request accepted this cycle
//   rd_e, rd_a, rd_i               : registered regfile write port

module u_rf_wb_arb #(
  parameter int NREQ = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_v,
  input  logic [4:0]  dec_rs1_a,
  input  logic [4:0]  dec_rs2_a,
  input  logic [4:0]  dec_rd_a,
  output logic        stall_o,
  input  logic        alu_v,
  input  logic        lsu_v,
  input  logic        mdu_v,
  input  logic [4:0]  alu_rd,
  input  logic [4:0]  lsu_rd,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] alu_d,
  input  logic [31:0] lsu_d,
  input  logic [31:0] mdu_d,
  output logic        alu_rdy,
  output logic        lsu_rdy,
  output logic        mdu_rdy,
  output logic        rd_e,
  output logic [4:0]  rd_a,
  output logic [31:0] rd_i
);

  import rv_pkg::*;

  wb_req_t           reqs [NREQ];
  logic [NREQ-1:0]   req_v;
  logic [NREQ-1:0]   gnt;
  logic              xfer;
  logic [REG_AW-1:0] sel_rd;
  logic [31:0]       sel_d;

  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_set;
  logic [NREGS-1:0]  pend_clr;

  assign reqs[REQ_ALU] = '{v: alu_v, rd: alu_rd, d: alu_d};
  assign reqs[REQ_LSU] = '{v: lsu_v, rd: lsu_rd, d: lsu_d};
  assign reqs[REQ_MDU] = '{v: mdu_v, rd: mdu_rd, d: mdu_d};

  always_comb begin
    req_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_v[i] = reqs[i].v;
    end
  end

  u_rr_arb #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_v),
    .gnt   (gnt)
  );

  // Grants are only raised on valid requests, so rdy alone marks a transfer.
  assign alu_rdy = gnt[REQ_ALU];
  assign lsu_rdy = gnt[REQ_LSU];
  assign mdu_rdy = gnt[REQ_MDU];

  // One-hot grant lets the data select be a plain AND-OR.
  always_comb begin
    xfer   = |gnt;
    sel_rd = '0;
    sel_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_rd = sel_rd | reqs[i].rd;
        sel_d  = sel_d  | reqs[i].d;
      end
    end
  end

  // A write to x0 is accepted and consumes the slot but never enables the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_e <= 1'b0;
      rd_a <= '0;
      rd_i <= '0;
    end else begin
      rd_e <= xfer & (sel_rd != '0);
      if (xfer) begin
        rd_a <= sel_rd;
        rd_i <= sel_d;
      end
    end
  end

  assign stall_o = dec_v & (src_hazard(pend, rd_e, rd_a, dec_rs1_a) |
                            src_hazard(pend, rd_e, rd_a, dec_rs2_a) |
                            src_hazard(pend, rd_e, rd_a, dec_rd_a));

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (dec_v && !stall_o && (dec_rd_a != '0)) begin
      pend_set[dec_rd_a] = 1'b1;
    end
    if (rd_e) begin
      pend_clr[rd_a] = 1'b1;
    end
  end

  // Set is applied after clear so an issue to the register being retired wins;
  // bit 0 is masked so x0 can never be pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= ((pend & ~pend_clr) | pend_set) & ~NREGS'(1);
    end
  end

endmodule

// File: tb/tb_u_rf_wb_arb.sv
// tb/tb_u_rf_wb_arb.sv - self-checking bench for u_rf_wb_arb

module tb_u_rf_wb_arb;

  logic        clk;
  logic        rst_n;
  logic        dec_v;
  logic [4:0]  dec_rs1_a, dec_rs2_a, dec_rd_a;
  logic        stall_o;
  logic [2:0]  bv;
  logic [4:0]  brd [3];
  logic [31:0] bd  [3];
  logic        alu_rdy, lsu_rdy, mdu_rdy;
  logic        rd_e;
  logic [4:0]  rd_a;
  logic [31:0] rd_i;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_last;
  logic [31:0] m_pend;
  logic        m_rd_e;
  logic [4:0]  m_rd_a;
  logic [31:0] m_rd_i;
  int          last_g;

  u_rf_wb_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dec_v     (dec_v),
    .dec_rs1_a (dec_rs1_a),
    .dec_rs2_a (dec_rs2_a),
    .dec_rd_a  (dec_rd_a),
    .stall_o   (stall_o),
    .alu_v     (bv[0]),
    .lsu_v     (bv[1]),
    .mdu_v     (bv[2]),
    .alu_rd    (brd[0]),
    .lsu_rd    (brd[1]),
    .mdu_rd    (brd[2]),
    .alu_d     (bd[0]),
    .lsu_d     (bd[1]),
    .mdu_d     (bd[2]),
    .alu_rdy   (alu_rdy),
    .lsu_rdy   (lsu_rdy),
    .mdu_rdy   (mdu_rdy),
    .rd_e      (rd_e),
    .rd_a      (rd_a),
    .rd_i      (rd_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (bv[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic m_hz(input logic [4:0] a);
    return m_pend[a] && !(m_rd_e && (m_rd_a == a));
  endfunction

  function automatic logic exp_stall();
    return dec_v && (m_hz(dec_rs1_a) || m_hz(dec_rs2_a) || m_hz(dec_rd_a));
  endfunction

  task automatic model_reset();
    m_last = 2;
    m_pend = '0;
    m_rd_e = 1'b0;
    m_rd_a = '0;
    m_rd_i = '0;
    last_g = -1;
  endtask

  task automatic set_idle();
    dec_v = 1'b0; dec_rs1_a = '0; dec_rs2_a = '0; dec_rd_a = '0;
    bv = '0;
  endtask

  // Checks one cycle against the model, advances the model over the coming
  // rising edge and returns at the next falling edge.
  task automatic cycle(input string tag);
    int          g;
    logic        st;
    logic [31:0] np;
    #1;
    g  = exp_grant();
    st = exp_stall();
    chk({tag, ".alu_rdy"}, alu_rdy, g == 0);
    chk({tag, ".lsu_rdy"}, lsu_rdy, g == 1);
    chk({tag, ".mdu_rdy"}, mdu_rdy, g == 2);
    chk({tag, ".stall"}, stall_o, st);
    chk({tag, ".rd_e"}, rd_e, m_rd_e);
    chk({tag, ".pend"}, dut.pend, m_pend);
    if (m_rd_e) begin
      chk({tag, ".rd_a"}, rd_a, m_rd_a);
      chk({tag, ".rd_i"}, rd_i, m_rd_i);
    end
    np = m_pend;
    if (m_rd_e) np[m_rd_a] = 1'b0;
    if (dec_v && !st && dec_rd_a != 0) np[dec_rd_a] = 1'b1;
    m_pend = np;
    if (g >= 0) begin
      m_last = g;
      m_rd_e = (brd[g] != 0);
      m_rd_a = brd[g];
      m_rd_i = bd[g];
    end else begin
      m_rd_e = 1'b0;
    end
    last_g = g;
    @(negedge clk);
  endtask

  initial begin
    int got;
    rst_n = 1'b0;
    set_idle();
    for (int i = 0; i < 3; i++) begin brd[i] = '0; bd[i] = '0; end
    model_reset();

    // Reset state
    #1;
    chk("rst.rd_e", rd_e, 0);
    chk("rst.rd_a", rd_a, 0);
    chk("rst.rd_i", rd_i, 0);
    chk("rst.stall", stall_o, 0);
    chk("rst.rdy", {alu_rdy, lsu_rdy, mdu_rdy}, 0);
    chk("rst.pend", dut.pend, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All three requesting from reset: ALU, LSU, MDU, ALU, ...
    bv = 3'b111;
    brd[0] = 5'd1; brd[1] = 5'd2; brd[2] = 5'd3;
    bd[0] = 32'hA000_0001; bd[1] = 32'hB000_0002; bd[2] = 32'hC000_0003;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("r24.order", {mdu_rdy, lsu_rdy, alu_rdy}, 32'd1 << (i % 3));
      if (i > 0) chk("r24.rd_e", rd_e, 1);
      cycle("r24");
    end
    set_idle();
    cycle("r24.tail");

    // RAW on x5 resolved by the LSU write, forwarded in the write cycle
    dec_v = 1'b1; dec_rd_a = 5'd5;
    cycle("r25.issue");
    dec_rd_a = 5'd0; dec_rs1_a = 5'd5;
    #1; chk("r25.stall0", stall_o, 1);
    cycle("r25.s0");
    cycle("r25.s1");
    bv[1] = 1'b1; brd[1] = 5'd5; bd[1] = 32'h0000_0555;
    #1; chk("r25.stall_gnt", stall_o, 1);
    cycle("r25.gnt");
    bv[1] = 1'b0;
    #1;
    chk("r25.wr_e", rd_e, 1);
    chk("r25.wr_a", rd_a, 5);
    chk("r25.nostall", stall_o, 0);
    cycle("r25.wr");
    dec_v = 1'b0; dec_rs1_a = 5'd0;
    #1; chk("r25.pend5", dut.pend[5], 0);
    cycle("r25.after");

    // Set beats clear on x7
    bv[1] = 1'b1; brd[1] = 5'd7; bd[1] = 32'h0000_0777;
    cycle("r26.gnt");
    bv[1] = 1'b0;
    dec_v = 1'b1; dec_rd_a = 5'd7;
    #1; chk("r26.wr_a", rd_a, 7);
    cycle("r26.both");
    dec_rd_a = 5'd0; dec_rs2_a = 5'd7;
    #1;
    chk("r26.pend7", dut.pend[7], 1);
    chk("r26.stall", stall_o, 1);
    cycle("r26.rs2");
    set_idle();
    bv[0] = 1'b1; brd[0] = 5'd7; bd[0] = 32'h0000_7777;
    cycle("r26.clr_gnt");
    bv[0] = 1'b0;
    cycle("r26.clr_wr");
    cycle("r26.clr_done");

    // Write to x0 is accepted but never enables the port
    bv[2] = 1'b1; brd[2] = 5'd0; bd[2] = 32'hDEAD_BEEF;
    dec_v = 1'b1; dec_rs1_a = 5'd0;
    #1; chk("r27.mdu_rdy", mdu_rdy, 1);
    cycle("r27.gnt");
    bv[2] = 1'b0;
    #1;
    chk("r27.rd_e", rd_e, 0);
    chk("r27.stall", stall_o, 0);
    cycle("r27.next");
    set_idle();

    // LSU held against competing ALU and MDU
    bv = 3'b100; brd[2] = 5'd3; bd[2] = 32'h3333_3333;
    cycle("r29.mdu");
    bv = 3'b111;
    brd[0] = 5'd1; brd[1] = 5'd2; bd[0] = 32'h1111_1111; bd[1] = 32'h2222_2222;
    got = 0;
    for (int k = 0; k < 2 && got == 0; k++) begin
      #1;
      if (lsu_rdy === 1'b1) got = 1;
      cycle("r29.wait");
    end
    chk("r29.lsu_within2", got, 1);
    set_idle();
    #1;
    chk("r29.rd_a", rd_a, 2);
    chk("r29.rd_i", rd_i, 32'h2222_2222);
    cycle("r29.wr");
    #1;
    chk("r16.idle_rd_e", rd_e, 0);
    chk("r16.hold_rd_a", rd_a, 2);
    chk("r16.hold_rd_i", rd_i, 32'h2222_2222);
    cycle("r16.idle");

    // Reset pulse with pending bits and a write in flight
    for (int r = 8; r < 12; r++) begin
      dec_v = 1'b1; dec_rd_a = 5'(r);
      if (r == 11) begin bv[0] = 1'b1; brd[0] = 5'd12; bd[0] = 32'h0C0C_0C0C; end
      cycle("r28.issue");
    end
    set_idle();
    #1;
    chk("r28.pend_pre", dut.pend, 32'h0000_0F00);
    chk("r28.rd_e_pre", rd_e, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r28.pend_rst", dut.pend, 0);
    chk("r28.rd_e_rst", rd_e, 0);
    chk("r28.rd_a_rst", rd_a, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    cycle("r28.post0");
    cycle("r28.post1");

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(bv[i] && last_g != i)) begin
          bv[i]  = ($urandom_range(0, 99) < 45);
          brd[i] = 5'($urandom_range(0, 7));
          bd[i]  = $urandom;
        end
      end
      dec_v     = ($urandom_range(0, 99) < 60);
      dec_rs1_a = 5'($urandom_range(0, 7));
      dec_rs2_a = 5'($urandom_range(0, 7));
      dec_rd_a  = 5'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
